// File: rtl/wb_dma_adr_cnt.sv
// Per-channel DMA address generator and transfer counter. Feeds the pipelined
// address incrementor and waits out its latency before accepting the next advance.
module wb_dma_adr_cnt #(
  parameter int AW      = 30,
  parameter int SZW     = 12,
  parameter int INC_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [AW-1:0]  ld_adr,
  input  logic [SZW-1:0] ld_sz,
  input  logic           inc_en,
  input  logic           clr,
  input  logic           adv,
  output logic           adv_rdy,
  output logic [AW-1:0]  adr,
  input  logic [AW-1:0]  adr_inc,
  output logic [SZW-1:0] sz_left,
  output logic           done,
  output logic           done_p
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Settle count is reloaded so that ACTIVE is reached INC_LAT edges after an address change.
  localparam logic [1:0] CNT_INIT = 2'(INC_LAT - 1);

  state_t         state_reg, state_next;
  logic [AW-1:0]  adr_reg, adr_next;
  logic [SZW-1:0] sz_reg, sz_next;
  logic [1:0]     cnt_reg, cnt_next;
  logic           adv_rdy_reg, adv_rdy_next;
  logic           done_reg, done_next;
  logic           done_p_reg, done_p_next;

  always_comb begin
    state_next   = state_reg;
    adr_next     = adr_reg;
    sz_next      = sz_reg;
    cnt_next     = cnt_reg;
    adv_rdy_next = 1'b0;
    done_next    = 1'b0;
    done_p_next  = 1'b0;

    if (clr) begin
      state_next = IDLE;
      sz_next    = '0;
    end else if (ld) begin
      adr_next = ld_adr;
      sz_next  = ld_sz;
      if (ld_sz == '0) begin
        state_next = DONE;
      end else begin
        state_next = SETTLE;
        cnt_next   = CNT_INIT;
      end
    end else begin
      case (state_reg)
        SETTLE: begin
          if (cnt_reg != 2'd0) cnt_next = cnt_reg - 2'd1;
          else                 state_next = ACTIVE;
        end
        ACTIVE: begin
          if (adv) begin
            sz_next = sz_reg - SZW'(1);
            if (inc_en) adr_next = adr_inc;
            if (sz_reg == SZW'(1)) begin
              state_next = DONE;
            end else if (inc_en) begin
              // A new address is in flight through the incrementor; wait for it.
              cnt_next   = CNT_INIT;
              state_next = SETTLE;
            end
          end
        end
        default: ;
      endcase
    end

    // Outputs are registered from the next state, so adv never reaches adv_rdy combinationally.
    adv_rdy_next = (state_next == ACTIVE);
    done_next    = (state_next == DONE);
    done_p_next  = (state_next == DONE) && (ld || state_reg != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      adr_reg     <= '0;
      sz_reg      <= '0;
      cnt_reg     <= 2'd0;
      adv_rdy_reg <= 1'b0;
      done_reg    <= 1'b0;
      done_p_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      adr_reg     <= adr_next;
      sz_reg      <= sz_next;
      cnt_reg     <= cnt_next;
      adv_rdy_reg <= adv_rdy_next;
      done_reg    <= done_next;
      done_p_reg  <= done_p_next;
    end
  end

  assign adv_rdy = adv_rdy_reg;
  assign adr     = adr_reg;
  assign sz_left = sz_reg;
  assign done    = done_reg;
  assign done_p  = done_p_reg;

endmodule

// File: tb/tb_wb_dma_adr_cnt.sv
// Bench for wb_dma_adr_cnt: two instances (INC_LAT=1 and 3) share one stimulus stream,
// each with its own pipelined incrementor and a transfer-level reference model.
module tb_wb_dma_adr_cnt;
  localparam int AW  = 30;
  localparam int SZW = 12;

  logic           clk = 1'b0;
  logic           rst, ld, inc_en, clr, adv;
  logic [AW-1:0]  ld_adr;
  logic [SZW-1:0] ld_sz;

  logic [AW-1:0]  adr1, adr3, adr_inc1, adr_inc3;
  logic [AW-1:0]  pipe3 [3];
  logic [SZW-1:0] sz1, sz3;
  logic           rdy1, rdy3, done1, done3, dp1, dp3;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wb_dma_adr_cnt #(.AW(AW), .SZW(SZW), .INC_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .ld(ld), .ld_adr(ld_adr), .ld_sz(ld_sz), .inc_en(inc_en),
    .clr(clr), .adv(adv), .adv_rdy(rdy1), .adr(adr1), .adr_inc(adr_inc1),
    .sz_left(sz1), .done(done1), .done_p(dp1)
  );

  wb_dma_adr_cnt #(.AW(AW), .SZW(SZW), .INC_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .ld(ld), .ld_adr(ld_adr), .ld_sz(ld_sz), .inc_en(inc_en),
    .clr(clr), .adv(adv), .adv_rdy(rdy3), .adr(adr3), .adr_inc(adr_inc3),
    .sz_left(sz3), .done(done3), .done_p(dp3)
  );

  // Incrementor models: output is only correct INC_LAT edges after the input changes.
  always @(posedge clk) begin
    adr_inc1 <= adr1 + 30'd1;
    pipe3[0] <= adr3 + 30'd1;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign adr_inc3 = pipe3[2];

  // Reference model: transfer bookkeeping with plain arithmetic.
  typedef struct {
    logic [AW-1:0]  adr;
    logic [SZW-1:0] left;
    bit             xfer;
    bit             done;
    bit             dp;
    int             wait_c;
  } model_t;

  model_t m1, m3;

  function automatic model_t step(input model_t m, input int lat);
    model_t n;
    n    = m;
    n.dp = 1'b0;
    if (rst) begin
      n.adr = '0; n.left = '0; n.xfer = 1'b0; n.done = 1'b0; n.wait_c = 0;
    end else if (clr) begin
      n.xfer = 1'b0; n.done = 1'b0; n.left = '0;
    end else if (ld) begin
      n.adr  = ld_adr;
      n.left = ld_sz;
      if (ld_sz == '0) begin
        n.xfer = 1'b0; n.done = 1'b1; n.dp = 1'b1;
      end else begin
        n.xfer = 1'b1; n.done = 1'b0; n.wait_c = lat;
      end
    end else if (m.xfer && m.wait_c == 0 && adv) begin
      n.left = m.left - 12'd1;
      if (inc_en) n.adr = m.adr + 30'd1;
      if (m.left == 12'd1) begin
        n.xfer = 1'b0; n.done = 1'b1; n.dp = 1'b1;
      end else if (inc_en) begin
        n.wait_c = lat;
      end
    end else if (m.xfer && m.wait_c > 0) begin
      n.wait_c = m.wait_c - 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 <= step(m1, 1);
    m3 <= step(m3, 3);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input model_t m, input logic [AW-1:0] a,
                     input logic [SZW-1:0] s, input logic r, input logic d, input logic p);
    chk({nm, " {adr,sz,rdy,done,done_p}"},
        {19'd0, a, s, r, d, p},
        {19'd0, m.adr, m.left, (m.xfer && m.wait_c == 0), m.done, m.dp});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("dut1", m1, adr1, sz1, rdy1, done1, dp1);
      cmp("dut3", m3, adr3, sz3, rdy3, done3, dp3);
    end
  end

  initial begin
    rst = 1'b1; ld = 1'b1; adv = 1'b1; clr = 1'b0; inc_en = 1'b1;
    ld_adr = 30'h55; ld_sz = 12'd3;
    repeat (2) @(negedge clk);
    $display("reset with ld/adv high");
    chk("rst adr1", adr1, 0);  chk("rst sz1", sz1, 0);  chk("rst rdy1", rdy1, 0);
    chk("rst done1", done1, 0); chk("rst dp1", dp1, 0);
    chk("rst adr3", adr3, 0);  chk("rst rdy3", rdy3, 0);
    chk_en = 1'b1;
    rst = 1'b0; ld = 1'b0; adv = 1'b0;
    @(negedge clk);

    // Basic run; the INC_LAT=3 instance covers the latency sweep.
    $display("load adr=100 sz=3 inc_en=1 adv held");
    ld = 1'b1; ld_adr = 30'h100; ld_sz = 12'd3; inc_en = 1'b1; adv = 1'b1;
    for (int e = 0; e < 14; e++) begin
      @(negedge clk);
      ld = 1'b0;
      case (e)
        0: chk("t2 rdy1 e0", rdy1, 0);
        1: begin chk("t2 rdy1 e1", rdy1, 1); chk("t2 sz1 e1", sz1, 3); end
        2: begin
          chk("t2 adr1 e2", adr1, 30'h101); chk("t2 sz1 e2", sz1, 2);
          chk("t2 rdy1 e2", rdy1, 0); chk("t6 rdy3 e2", rdy3, 0);
        end
        3: chk("t6 rdy3 e3", rdy3, 1);
        4: begin chk("t2 adr1 e4", adr1, 30'h102); chk("t6 adr3 e4", adr3, 30'h101); end
        6: begin
          chk("t2 adr1 e6", adr1, 30'h103); chk("t2 sz1 e6", sz1, 0);
          chk("t2 done1 e6", done1, 1); chk("t2 dp1 e6", dp1, 1);
          chk("model m1 adr e6", m1.adr, 30'h103);
        end
        7: begin chk("t2 dp1 e7", dp1, 0); chk("t2 done1 e7", done1, 1); chk("t6 rdy3 e7", rdy3, 1); end
        12: begin chk("t6 adr3 e12", adr3, 30'h103); chk("t6 done3 e12", done3, 1); chk("t6 dp3 e12", dp3, 1); end
        default: ;
      endcase
    end

    $display("load adr=2000 sz=4 inc_en=0 adv held");
    ld = 1'b1; ld_adr = 30'h2000; ld_sz = 12'd4; inc_en = 1'b0; adv = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      ld = 1'b0;
      case (e)
        1: begin chk("t3 rdy1 e1", rdy1, 1); chk("t3 sz1 e1", sz1, 4); end
        2: begin chk("t3 rdy1 e2", rdy1, 1); chk("t3 sz1 e2", sz1, 3); chk("t3 adr1 e2", adr1, 30'h2000); end
        5: begin
          chk("t3 done1 e5", done1, 1); chk("t3 dp1 e5", dp1, 1);
          chk("t3 sz1 e5", sz1, 0); chk("t3 adr1 e5", adr1, 30'h2000);
        end
        7: begin chk("t3 done3 e7", done3, 1); chk("t3 dp3 e7", dp3, 1); chk("t3 adr3 e7", adr3, 30'h2000); end
        default: ;
      endcase
    end

    $display("load adr=3fffffff sz=2 inc_en=1 adv held");
    ld = 1'b1; ld_adr = 30'h3FFFFFFF; ld_sz = 12'd2; inc_en = 1'b1; adv = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      ld = 1'b0;
      case (e)
        2: begin chk("t4 adr1 e2", adr1, 30'h0); chk("t4 sz1 e2", sz1, 1); end
        4: begin chk("t4 adr1 e4", adr1, 30'h1); chk("t4 done1 e4", done1, 1); chk("t4 adr3 e4", adr3, 30'h0); end
        8: begin chk("t4 adr3 e8", adr3, 30'h1); chk("t4 done3 e8", done3, 1); end
        default: ;
      endcase
    end

    $display("load adr=777 sz=0");
    ld = 1'b1; ld_adr = 30'h777; ld_sz = 12'd0;
    @(negedge clk);
    ld = 1'b0;
    chk("t4z done1", done1, 1); chk("t4z dp1", dp1, 1); chk("t4z rdy1", rdy1, 0);
    chk("t4z adr1", adr1, 30'h777); chk("t4z sz1", sz1, 0); chk("t4z dp3", dp3, 1);
    chk("model m3 dp", m3.dp, 1);
    @(negedge clk);
    chk("t4z dp1 next", dp1, 0); chk("t4z done1 next", done1, 1);

    $display("load adr=10 sz=9, then ld+adv collision, then clr+ld");
    ld = 1'b1; ld_adr = 30'h10; ld_sz = 12'd9; inc_en = 1'b1; adv = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    chk("t5 rdy1 before", rdy1, 1);
    ld = 1'b1; ld_adr = 30'h50; ld_sz = 12'd5;
    @(negedge clk);
    chk("t5 adr1", adr1, 30'h50); chk("t5 sz1", sz1, 5); chk("t5 rdy1", rdy1, 0);
    clr = 1'b1; ld = 1'b1; ld_adr = 30'h60; ld_sz = 12'd3;
    @(negedge clk);
    chk("t5 clr sz1", sz1, 0); chk("t5 clr rdy1", rdy1, 0); chk("t5 clr done1", done1, 0);
    chk("t5 clr adr1", adr1, 30'h50); chk("t5 clr sz3", sz3, 0);
    clr = 1'b0; ld = 1'b0;
    @(negedge clk);
    chk("t5 idle rdy1", rdy1, 0);

    $display("load adr=400 sz=7, then abort");
    ld = 1'b1; ld_adr = 30'h400; ld_sz = 12'd7; inc_en = 1'b0; adv = 1'b0;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    chk("t6 rdy1 pre", rdy1, 1); chk("t6 sz1 pre", sz1, 7);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t6 abort rdy1", rdy1, 0); chk("t6 abort sz1", sz1, 0);
    chk("t6 abort adr1", adr1, 30'h400); chk("t6 abort done1", done1, 0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      if (ld) begin
        ld_adr = ($urandom_range(0, 3) == 0) ? 30'(32'h3FFFFFFF - $urandom_range(0, 3)) : 30'($urandom);
        ld_sz  = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 8));
        $display("load adr=%h sz=%0d rst=%0d clr=%0d", ld_adr, ld_sz, rst, clr);
      end
      if ($urandom_range(0, 7) == 0) inc_en = ~inc_en;
      adv = ($urandom_range(0, 9) < 7);
    end

    @(negedge clk);
    rst = 1'b0; clr = 1'b0; ld = 1'b0; adv = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
